// File: rtl/pit_irq_latch_if.sv
// pit_irq_latch_if: timer-event, host-handshake and status signals of pit_irq_latch.
interface pit_irq_latch_if #(parameter int CNT_W = 4);
  logic irq_pulse;
  logic irq_mask;
  logic ack_req;
  logic clr;
  logic irq_out;
  logic ack_ack;
  logic [CNT_W-1:0] pending_cnt;
  logic overrun;
  modport master (output irq_pulse, irq_mask, ack_req, clr, input irq_out, ack_ack, pending_cnt, overrun);
  modport slave  (input irq_pulse, irq_mask, ack_req, clr, output irq_out, ack_ack, pending_cnt, overrun);
endinterface

// File: rtl/pit_irq_latch.sv
// pit_irq_latch: counts timer interrupt edges, raises a level irq, retires one event per 4-phase ack.
// Define PIT_IRQ_ACK_SYNC_EN to pass ack_req through a 2-flop synchronizer.
module pit_irq_latch #(parameter int CNT_W = 4) (
  input logic clk,
  input logic rst_n,
  pit_irq_latch_if.slave bus
);
  typedef enum logic {IDLE, ACKED} state_t;
  state_t state;
  logic irq_prev, ack_s, ev, dec, ovr;
  logic [CNT_W-1:0] cnt;
`ifdef PIT_IRQ_ACK_SYNC_EN
  logic [1:0] ack_sync;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ack_sync <= '0;
    else ack_sync <= {ack_sync[0], bus.ack_req};
  assign ack_s = ack_sync[1];
`else
  assign ack_s = bus.ack_req;
`endif
  assign ev = bus.irq_pulse & ~irq_prev;
  // only the IDLE->ACKED transition retires an event, so a long ack_req costs one
  assign dec = (state == IDLE) & ack_s & (cnt != '0);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      irq_prev <= 1'b0;
      state <= IDLE;
    end else begin
      irq_prev <= bus.irq_pulse;
      state <= ack_s ? ACKED : IDLE;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      ovr <= 1'b0;
    end else if (bus.clr) begin
      cnt <= '0;
      ovr <= 1'b0;
    end else if (ev && !dec) begin
      if (cnt == '1) ovr <= 1'b1;
      else cnt <= cnt + 1'b1;
    end else if (dec && !ev) begin
      cnt <= cnt - 1'b1;
    end
  assign bus.pending_cnt = cnt;
  assign bus.overrun = ovr;
  assign bus.ack_ack = (state == ACKED);
  assign bus.irq_out = (cnt != '0) & ~bus.irq_mask;
endmodule
